zeroriscy_instr_responder: RTL and testbench
============================================

# zeroriscy_instr_responder

Instruction-side memory responder: the slave end of the core's instr_req/gnt/rvalid fetch protocol. Holds a word-addressed program RAM with a backdoor load port. Grants fetches after a configurable delay and returns in-order read data after a fixed latency, with bounded outstanding requests. Sits between the core's fetch port and on-chip program memory; also serves as the fetch-side model in core-level benches.

## Interface
- MEM_WORDS_LOG2, 12: RAM depth is 2**MEM_WORDS_LOG2 32-bit words.
- GNT_DELAY, 0: cycles from a new request to gnt (0..7; 0 = same-cycle grant).
- RESP_LAT, 1: cycles from the gnt cycle to the rvalid cycle (1..4).
- MAX_OUTST, 2: maximum granted-but-not-responded requests (1..4).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_req_i  in  1  fetch request; held until granted.
- instr_addr_i  in  32  byte address, sampled in the gnt cycle.
- instr_gnt_o  out  1  request accepted this cycle.
- instr_rvalid_o  out  1  instr_rdata_o valid this cycle.
- instr_rdata_o  out  32  fetched word.
- base_addr_i  in  32  byte base of the RAM window; quasi-static.
- stall_i  in  1  suppresses gnt this cycle (backpressure injection).
- load_we_i  in  1  backdoor write enable.
- load_addr_i  in  MEM_WORDS_LOG2  backdoor word index.
- load_wdata_i  in  32  backdoor write data.
- busy_o  out  1  outstanding count nonzero.

## Operation
- Grant FSM: IDLE, WAIT, GRANT.
  - IDLE: on instr_req_i, go to WAIT with cnt=0.
  - WAIT: cnt increments each cycle.
  - GRANT is the cycle where cnt==GNT_DELAY and req is held.
  - With GNT_DELAY=0, the grant is evaluated in the first request cycle.
- instr_gnt_o = instr_req_i & delay met & (outst < MAX_OUTST) & ~stall_i.
  - A blocked grant stays pending, and the counter saturates at GNT_DELAY.
  - After gnt, a still-high req restarts the count next cycle.
- Req dropped before gnt: return to IDLE, clear cnt, issue no grant.
- On gnt: offset = instr_addr_i - base_addr_i (32-bit unsigned, wraps).
  - In range if offset < 4*2**MEM_WORDS_LOG2; index = offset[MEM_WORDS_LOG2+1:2]; addr[1:0] ignored.
  - Out of range returns 32'h0000_0000, which decodes as illegal and traps.
- Response pipe: RESP_LAT stages of {valid, in_range, data}, shifted every cycle; no response backpressure. Responses are strictly in grant order.
- outst: +1 on gnt, -1 on rvalid, unchanged if both occur in the same cycle; never exceeds MAX_OUTST.
- Backdoor write: takes effect at the clock edge. A same-cycle read of the same word returns the old data (read-before-write).
- Reset: gnt=0, rvalid=0, rdata=0, busy=0, outst=0, FSM=IDLE, pipe valids cleared, so in-flight responses are dropped. RAM contents are not reset.
- instr_rdata_o holds its last value when rvalid=0.

## Timing
- Request first high at cycle t, no stall, outst<MAX_OUTST: gnt at t+GNT_DELAY; rvalid at t+GNT_DELAY+RESP_LAT.
- Back-to-back with GNT_DELAY=0, RESP_LAT=1: one gnt and one rvalid per cycle (full throughput).
- Throughput with outst==MAX_OUTST: gnt is held low until a rvalid occurs. The grant can then fire in that same rvalid cycle.
- RAM read is synchronous, issued in the gnt cycle. RESP_LAT=1 means data is straight from the RAM output register.

## Structure
- Package zeroriscy_instr_resp_pkg: grant FSM state enum (IDLE/WAIT/GRANT) and the out-of-range return constant (32'h0).
- Sub-module zeroriscy_instr_ram:
  - Single clock, one synchronous read port, one write port.
  - Depth 2**MEM_WORDS_LOG2; no reset on the array.
- Top holds the FSM, the outstanding counter and the response pipe.

## Test plan
- GNT_DELAY=0, RESP_LAT=1, RAM preloaded with word i = i: req at addr base+0x10 for one cycle -> gnt in the same cycle, rvalid next cycle with rdata=4.
- GNT_DELAY=3: req held from cycle t -> gnt at t+3 only; drop req at t+2 -> no gnt, FSM back to IDLE.
- MAX_OUTST=2, RESP_LAT=4, req held continuously:
  - gnt in cycles t and t+1, then low until the first rvalid at t+4; gnt again at t+4.
  - Responses return in order.
- Address below base_addr_i and at base+4*2**MEM_WORDS_LOG2 -> rvalid with rdata=0; outst returns to 0.
- Backdoor write 0xDEADBEEF to index 5 in the same cycle as a gnt for index 5 -> old data returned; a refetch returns 0xDEADBEEF.
- Assert rst while 2 responses are in flight -> no rvalid after reset; gnt=0, busy=0 in the cycle after reset.

Source files
------------

// File: rtl/zeroriscy_instr_resp_pkg.sv
// Shared types and constants for the instruction-side fetch responder.
package zeroriscy_instr_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT
  } gnt_state_e;

  // Returned for fetches outside the RAM window; decodes as an illegal instruction.
  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/zeroriscy_instr_ram.sv
// Program RAM: one synchronous read port, one write port, read-before-write on collision.
module zeroriscy_instr_ram #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/zeroriscy_instr_responder.sv
// Slave end of the instr_req/gnt/rvalid fetch protocol: delayed grant, bounded
// outstanding requests and a fixed-latency in-order response pipe.
module zeroriscy_instr_responder
  import zeroriscy_instr_resp_pkg::*;
#(
  parameter int unsigned MEM_WORDS_LOG2 = 12,
  parameter int unsigned GNT_DELAY      = 0,
  parameter int unsigned RESP_LAT       = 1,
  parameter int unsigned MAX_OUTST      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_req_i,
  input  logic [31:0]               instr_addr_i,
  output logic                      instr_gnt_o,
  output logic                      instr_rvalid_o,
  output logic [31:0]               instr_rdata_o,
  input  logic [31:0]               base_addr_i,
  input  logic                      stall_i,
  input  logic                      load_we_i,
  input  logic [MEM_WORDS_LOG2-1:0] load_addr_i,
  input  logic [31:0]               load_wdata_i,
  output logic                      busy_o
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);

  gnt_state_e           state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [2:0]           cnt_cur;
  logic                 delay_met;
  logic                 room;
  logic                 gnt;
  logic                 rvalid;
  logic [OUT_W-1:0]     outst_q, outst_d;
  logic [RESP_LAT-1:0]  valid_q;
  logic                 inr_q;
  logic [31:0]          offset;
  logic                 in_range;
  logic [31:0]          ram_rdata;
  logic [31:0]          stage0_data;
  logic [31:0]          resp_data;
  logic [31:0]          rdata_hold_q;

  // The first request cycle counts as cnt==0 even though the register still holds IDLE.
  assign cnt_cur   = (state_q == IDLE) ? 3'd0 : cnt_q;
  assign delay_met = (state_q == GRANT) || (cnt_cur == 3'(GNT_DELAY));
  assign rvalid    = valid_q[RESP_LAT-1] & ~rst;
  // A response leaving this cycle frees a slot for a same-cycle grant.
  assign room      = (outst_q < OUT_W'(MAX_OUTST)) | rvalid;
  assign gnt       = instr_req_i & delay_met & room & ~stall_i & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!instr_req_i || gnt) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE, WAIT: begin
          if (delay_met) begin
            state_d = GRANT;
            cnt_d   = 3'(GNT_DELAY);
          end else begin
            state_d = WAIT;
            cnt_d   = cnt_cur + 3'd1;
          end
        end
        GRANT:   state_d = GRANT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    outst_d = outst_q;
    case ({gnt, rvalid})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_q <= '0;
    end else begin
      outst_q <= outst_d;
    end
  end

  assign offset   = instr_addr_i - base_addr_i;
  assign in_range = (offset >> (MEM_WORDS_LOG2 + 2)) == 32'd0;

  zeroriscy_instr_ram #(
    .ADDR_W (MEM_WORDS_LOG2)
  ) u_ram (
    .clk     (clk),
    .re_i    (gnt & in_range),
    .raddr_i (offset[MEM_WORDS_LOG2+1:2]),
    .rdata_o (ram_rdata),
    .we_i    (load_we_i),
    .waddr_i (load_addr_i),
    .wdata_i (load_wdata_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= gnt;
      for (int i = 1; i < int'(RESP_LAT); i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    inr_q <= in_range;
  end

  assign stage0_data = inr_q ? ram_rdata : OOR_RDATA;

  if (RESP_LAT == 1) begin : g_lat1
    assign resp_data = stage0_data;
  end else begin : g_latn
    logic [31:0] data_q [RESP_LAT-1];
    always_ff @(posedge clk) begin
      data_q[0] <= stage0_data;
      for (int i = 1; i < int'(RESP_LAT) - 1; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
    assign resp_data = data_q[RESP_LAT-2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_hold_q <= 32'd0;
    end else if (rvalid) begin
      rdata_hold_q <= resp_data;
    end
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rvalid;
  assign instr_rdata_o  = rvalid ? resp_data : rdata_hold_q;
  assign busy_o         = outst_q != '0;

endmodule

// File: tb/tb_zeroriscy_instr_responder.sv
// Three responder configurations driven by directed and random fetch traffic,
// each checked cycle by cycle against a queue-based reference model.
module tb_zeroriscy_instr_responder;

  localparam int LOG2  = 4;
  localparam int WORDS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int GD = (gi == 1) ? 3 : 0;
    localparam int RL = (gi == 2) ? 4 : 1;
    localparam int MO = 2;

    logic            rst, req, stall, we;
    logic [31:0]     addr, base, wdata;
    logic [LOG2-1:0] widx;
    logic            gnt, rvalid, busy;
    logic [31:0]     rdata;
    bit              done = 1'b0;

    zeroriscy_instr_responder #(
      .MEM_WORDS_LOG2 (LOG2),
      .GNT_DELAY      (GD),
      .RESP_LAT       (RL),
      .MAX_OUTST      (MO)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .instr_req_i    (req),
      .instr_addr_i   (addr),
      .instr_gnt_o    (gnt),
      .instr_rvalid_o (rvalid),
      .instr_rdata_o  (rdata),
      .base_addr_i    (base),
      .stall_i        (stall),
      .load_we_i      (we),
      .load_addr_i    (widx),
      .load_wdata_i   (wdata),
      .busy_o         (busy)
    );

    // Reference model: cycles a request has waited, and a queue of pending responses.
    int          age = 0;
    int          cyc = 0;
    int          due_q[$];
    logic [31:0] dat_q[$];
    logic [31:0] mem_m [WORDS];
    logic [31:0] last_rd = 32'd0;
    bit          m_gnt = 1'b0;
    logic        o_gnt, o_rv, o_busy;
    logic [31:0] o_rd;

    task automatic cycle();
      logic [31:0] off;
      bit eg, ev;
      eg = 1'b0;
      ev = 1'b0;
      @(negedge clk);
      o_gnt  = gnt;
      o_rv   = rvalid;
      o_rd   = rdata;
      o_busy = busy;
      if (rst) begin
        due_q.delete();
        dat_q.delete();
        age     = 0;
        last_rd = 32'd0;
      end else begin
        ev = (due_q.size() != 0) && (due_q[0] == cyc);
        eg = req && (age >= GD) && ((due_q.size() < MO) || ev) && !stall;
        check($sformatf("c%0d_gnt@%0d", gi, cyc), 32'(gnt), 32'(eg));
        check($sformatf("c%0d_rvalid@%0d", gi, cyc), 32'(rvalid), 32'(ev));
        check($sformatf("c%0d_busy@%0d", gi, cyc), 32'(busy), 32'(due_q.size() != 0));
        if (ev) begin
          last_rd = dat_q[0];
          void'(due_q.pop_front());
          void'(dat_q.pop_front());
        end
        check($sformatf("c%0d_rdata@%0d", gi, cyc), rdata, last_rd);
        if (eg) begin
          off = addr - base;
          due_q.push_back(cyc + RL);
          dat_q.push_back((off < 32'(4 * WORDS)) ? mem_m[off[LOG2+1:2]] : 32'h0);
        end
        age = (eg || !req) ? 0 : age + 1;
      end
      if (we) mem_m[widx] = wdata;
      m_gnt = eg;
      cyc++;
      @(posedge clk);
      #1;
    endtask

    // One fetch from request to response; optionally collides a backdoor write to word 5.
    task automatic fetch(input logic [31:0] a, input bit coll, output logic [31:0] d, output int lat);
      bit granted, found;
      granted = 1'b0;
      found   = 1'b0;
      d       = 32'd0;
      lat     = -1;
      req     = 1'b1;
      addr    = a;
      for (int n = 0; n < 40 && !found; n++) begin
        we    = coll && !granted && (age == GD);
        widx  = 4'd5;
        wdata = 32'hDEAD_BEEF;
        cycle();
        if (o_gnt) begin
          granted = 1'b1;
          req     = 1'b0;
        end
        if (o_rv) begin
          found = 1'b1;
          d     = o_rd;
          lat   = n;
        end
      end
      req = 1'b0;
      we  = 1'b0;
      check($sformatf("c%0d_fetch_done", gi), 32'(found), 32'd1);
      $display("cfg%0d fetch addr=%h rdata=%h lat=%0d", gi, a, d, lat);
    endtask

    initial begin
      logic [31:0] d;
      int lat, cnt;
      rst   = 1'b1;
      req   = 1'b0;
      stall = 1'b0;
      we    = 1'b0;
      widx  = '0;
      wdata = 32'd0;
      addr  = 32'd0;
      base  = $urandom & 32'hFFFF_FFC0;
      cycle();
      cycle();
      rst = 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        we    = 1'b1;
        widx  = LOG2'(i);
        wdata = 32'(i);
        cycle();
      end
      we = 1'b0;

      fetch(base + 32'h10, 1'b0, d, lat);
      check($sformatf("c%0d_word4", gi), d, 32'd4);
      check($sformatf("c%0d_latency", gi), 32'(lat), 32'(GD + RL));
      fetch(base + 32'h13, 1'b0, d, lat);
      check($sformatf("c%0d_low_bits_ignored", gi), d, 32'd4);
      fetch(base + 32'h14, 1'b1, d, lat);
      check($sformatf("c%0d_collide_old", gi), d, 32'd5);
      fetch(base + 32'h14, 1'b0, d, lat);
      check($sformatf("c%0d_refetch_new", gi), d, 32'hDEAD_BEEF);
      fetch(base - 32'd4, 1'b0, d, lat);
      check($sformatf("c%0d_below_base", gi), d, 32'd0);
      fetch(base + 32'(4 * WORDS), 1'b0, d, lat);
      check($sformatf("c%0d_above_window", gi), d, 32'd0);
      cycle();
      check($sformatf("c%0d_idle_busy", gi), 32'(o_busy), 32'd0);

      // Request withdrawn one cycle before its grant would be due.
      cnt  = 0;
      req  = 1'b1;
      addr = base;
      for (int k = 0; k < GD; k++) begin
        cycle();
        cnt += int'(o_gnt);
      end
      req = 1'b0;
      for (int k = 0; k < 4; k++) begin
        cycle();
        cnt += int'(o_gnt);
      end
      check($sformatf("c%0d_dropped_no_gnt", gi), 32'(cnt), 32'd0);

      // Continuous requests saturate the outstanding limit.
      req = 1'b1;
      for (int k = 0; k < 10; k++) begin
        addr = base + 32'(4 * k);
        cycle();
      end
      req = 1'b0;
      repeat (8) cycle();

      // Reset with two responses in flight.
      cnt  = 0;
      req  = 1'b1;
      addr = base + 32'h8;
      for (int k = 0; k < 20 && cnt < 2; k++) begin
        cycle();
        cnt += int'(o_gnt);
      end
      req = 1'b0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      check($sformatf("c%0d_post_rst_gnt", gi), 32'(o_gnt), 32'd0);
      check($sformatf("c%0d_post_rst_busy", gi), 32'(o_busy), 32'd0);
      cnt = int'(o_rv);
      repeat (6) begin
        cycle();
        cnt += int'(o_rv);
      end
      check($sformatf("c%0d_post_rst_rvalid", gi), 32'(cnt), 32'd0);

      // Random traffic with stalls, backdoor writes and occasional resets.
      for (int n = 0; n < 1500; n++) begin
        if (rst) begin
          rst = 1'b0;
        end else if ($urandom_range(0, 299) == 0) begin
          rst = 1'b1;
        end
        if (req && !m_gnt) begin
          if ($urandom_range(0, 7) == 0) req = 1'b0;
        end else begin
          req = ($urandom_range(0, 3) != 0);
          case ($urandom_range(0, 9))
            0:       addr = base - 32'(4 * $urandom_range(1, 3));
            1:       addr = base + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 3));
            default: addr = base + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(0, 3));
          endcase
        end
        stall = ($urandom_range(0, 5) == 0);
        we    = ($urandom_range(0, 3) == 0);
        widx  = LOG2'($urandom_range(0, WORDS - 1));
        wdata = $urandom;
        if (rst) begin
          req = 1'b0;
          we  = 1'b0;
        end
        cycle();
      end
      req   = 1'b0;
      we    = 1'b0;
      stall = 1'b0;
      rst   = 1'b0;
      repeat (8) cycle();
      done = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("all_cfgs_done", 32'(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
